bck_loop_ctrl_stage: RTL and testbench
======================================

Name: bck_loop_ctrl_stage

Overview:
- Second stage of the backward-extension SMEM pipeline. It advances the inner j loop (over last-iteration intervals) and the outer i loop (read position), and flags iteration boundary and per-read finish.
- Parametrised successor of the fixed-width stall-driven stage. It replaces the global stall with a valid/ready handshake and a 1-entry skid buffer, adds a programmable i floor, counts finished reads, and reports unknown-status errors.

Parameters:
READ_NUM_W, 10, read index width
SIZE_W, 7, width of interval counts, j, and addresses
POS_W, 7, width of read position i
PRIM_W, 64, primary payload width
RSV_W, 96, reserved token + mem-info passthrough width
CNT_W, 16, finish counter width
I_FLOOR, 0, lowest i processed; reaching it ends the read
ST_INI, 6'h1, BCK_INI code
ST_RUN, 6'h2, BCK_RUN code
ST_BUBBLE, 6'h1e, BUBBLE code

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat
in_status  in  6  token status
in_read_num  in  READ_NUM_W  read index
in_primary  in  PRIM_W  primary
in_fwd_size_n, in_new_size, in_new_last_size  in  SIZE_W each  interval counts
in_cur_wr_addr, in_cur_rd_addr, in_mem_wr_addr  in  SIZE_W each  addresses
in_bck_i  in  POS_W  read position
in_bck_j  in  SIZE_W  inner index
in_output_c  in  8  output char
in_min_intv  in  SIZE_W  minimum interval
in_iter_bound  in  1  incoming iteration-boundary flag
in_reserved  in  RSV_W  passthrough
out_valid  out  1  beat valid
out_ready  in  1  downstream accepts
out_* (status, read_num, primary, fwd_size_n, new_size, new_last_size, cur_wr_addr, cur_rd_addr, mem_wr_addr, bck_i, bck_j, output_c, min_intv, reserved)  out  same widths as inputs  registered results
finish_sign  out  1  read finished
iteration_boundary  out  1  i loop exhausted
finish_cnt  out  CNT_W  saturating count of finish beats delivered
cnt_clr  in  1  synchronous clear of finish_cnt
err_status  out  1  sticky: unknown status seen

Behaviour:
- Reset (rst=0, asynchronous):
  - All out_* = 0 except out_status = ST_BUBBLE.
  - out_valid = 0, finish_sign = 0, iteration_boundary = 0.
  - Skid buffer empty; finish_cnt = 0; err_status = 0.
  - Reset mid-operation discards both registered beats.
- Handshake:
  - A beat transfers when valid & ready.
  - in_ready = !skid_full (registered).
  - Latency is 1 cycle when out_ready is held high.
  - If the output register holds an unaccepted beat and a new beat is accepted, the new result goes to the skid buffer. The skid buffer drains into the output register on the next out_ready.
  - Output holds stable while out_valid & !out_ready.
  - No beat is lost or duplicated.
- Compute (combinational, from the accepted beat):
  - ST_INI: pass all fields through; output_c = 0; finish_sign = 0; iteration_boundary = in_iter_bound.
  - ST_RUN:
    - j_bound = (in_bck_j == in_new_last_size - 1), computed modulo 2^SIZE_W. new_last_size = 0 therefore compares against all-ones.
    - i_step = j_bound & (in_bck_i > I_FLOOR); i_end = j_bound & (in_bck_i == I_FLOOR).
    - finish_sign = j_bound & (in_new_size == 0).
    - iteration_boundary = in_iter_bound | i_end.
    - bck_i = in_iter_bound ? I_FLOOR : (i_step ? in_bck_i - 1 : in_bck_i).
    - bck_j = j_bound ? 0 : in_bck_j + 1 (wraps modulo 2^SIZE_W).
    - cur_wr_addr = j_bound ? in_fwd_size_n - 1 : in_cur_wr_addr.
    - new_last_size = j_bound ? in_new_size : in_new_last_size.
    - new_size = j_bound ? 0 : in_new_size.
    - All other fields pass through.
  - ST_BUBBLE: the beat is still delivered; all fields 0, status ST_BUBBLE, flags 0.
  - Any other status: delivered as a BUBBLE beat and err_status set (sticky until reset).
- finish_cnt:
  - Increments on each output transfer with finish_sign = 1, saturating at all-ones.
  - cnt_clr has priority over an increment in the same cycle.

Test Plan:
- ST_RUN, j=2, new_last_size=3, i=5, new_size=4, fwd_size_n=10, iter_bound=0 -> bck_j=0, bck_i=4, new_last_size=4, new_size=0, cur_wr_addr=9, finish=0, boundary=0, 1-cycle latency.
- ST_RUN, j=2, new_last_size=3, i=0, new_size=0 -> finish=1, boundary=1, bck_i=0, finish_cnt +1. With I_FLOOR=3 and i=3, same flags.
- ST_RUN, new_last_size=0, j=127 -> j_bound true, bck_j=0. j=5 with new_last_size=9 -> bck_j=6, other fields unchanged.
- Stream of 4 beats with out_ready low for cycles 2-4 -> in_ready drops after the skid fills; all 4 beats are delivered in order with values intact.
- ST_INI, output_c=0x41 -> out_output_c=0, finish=0. ST_BUBBLE -> zero beat. Status 6'h3f -> bubble beat, err_status=1.
- Assert rst mid-stall with both entries full -> outputs return to reset values asynchronously. Then hold finish_cnt at all-ones and deliver a finish beat -> stays saturated. cnt_clr together with a finish beat -> 0.

Source files
------------

// File: rtl/bck_loop_ctrl_stage.sv
// Backward-extension SMEM loop-control stage: advances the j/i loops per beat,
// flags read finish and iteration boundary, with a valid/ready output and 1-entry skid buffer.
module bck_loop_ctrl_stage #(
    parameter int         READ_NUM_W = 10,
    parameter int         SIZE_W     = 7,
    parameter int         POS_W      = 7,
    parameter int         PRIM_W     = 64,
    parameter int         RSV_W      = 96,
    parameter int         CNT_W      = 16,
    parameter int         I_FLOOR    = 0,
    parameter logic [5:0] ST_INI     = 6'h1,
    parameter logic [5:0] ST_RUN     = 6'h2,
    parameter logic [5:0] ST_BUBBLE  = 6'h1e
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [5:0]            in_status,
    input  logic [READ_NUM_W-1:0] in_read_num,
    input  logic [PRIM_W-1:0]     in_primary,
    input  logic [SIZE_W-1:0]     in_fwd_size_n,
    input  logic [SIZE_W-1:0]     in_new_size,
    input  logic [SIZE_W-1:0]     in_new_last_size,
    input  logic [SIZE_W-1:0]     in_cur_wr_addr,
    input  logic [SIZE_W-1:0]     in_cur_rd_addr,
    input  logic [SIZE_W-1:0]     in_mem_wr_addr,
    input  logic [POS_W-1:0]      in_bck_i,
    input  logic [SIZE_W-1:0]     in_bck_j,
    input  logic [7:0]            in_output_c,
    input  logic [SIZE_W-1:0]     in_min_intv,
    input  logic                  in_iter_bound,
    input  logic [RSV_W-1:0]      in_reserved,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [5:0]            out_status,
    output logic [READ_NUM_W-1:0] out_read_num,
    output logic [PRIM_W-1:0]     out_primary,
    output logic [SIZE_W-1:0]     out_fwd_size_n,
    output logic [SIZE_W-1:0]     out_new_size,
    output logic [SIZE_W-1:0]     out_new_last_size,
    output logic [SIZE_W-1:0]     out_cur_wr_addr,
    output logic [SIZE_W-1:0]     out_cur_rd_addr,
    output logic [SIZE_W-1:0]     out_mem_wr_addr,
    output logic [POS_W-1:0]      out_bck_i,
    output logic [SIZE_W-1:0]     out_bck_j,
    output logic [7:0]            out_output_c,
    output logic [SIZE_W-1:0]     out_min_intv,
    output logic [RSV_W-1:0]      out_reserved,
    output logic                  finish_sign,
    output logic                  iteration_boundary,
    output logic [CNT_W-1:0]      finish_cnt,
    input  logic                  cnt_clr,
    output logic                  err_status
);

    typedef struct packed {
        logic [5:0]            status;
        logic [READ_NUM_W-1:0] read_num;
        logic [PRIM_W-1:0]     primary;
        logic [SIZE_W-1:0]     fwd_size_n;
        logic [SIZE_W-1:0]     new_size;
        logic [SIZE_W-1:0]     new_last_size;
        logic [SIZE_W-1:0]     cur_wr_addr;
        logic [SIZE_W-1:0]     cur_rd_addr;
        logic [SIZE_W-1:0]     mem_wr_addr;
        logic [POS_W-1:0]      bck_i;
        logic [SIZE_W-1:0]     bck_j;
        logic [7:0]            output_c;
        logic [SIZE_W-1:0]     min_intv;
        logic [RSV_W-1:0]      reserved;
        logic                  finish;
        logic                  boundary;
    } beat_t;

    localparam logic [POS_W-1:0] I_FLOOR_P = POS_W'(I_FLOOR);

    function automatic beat_t bubble_beat();
        beat_t b;
        b        = '0;
        b.status = ST_BUBBLE;
        return b;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    beat_t             w_in;
    beat_t             w_res;
    logic              w_unknown;
    logic              w_jbound;
    logic              w_i_step;
    logic              w_i_end;
    logic [SIZE_W-1:0] w_last_m1;
    logic [SIZE_W-1:0] w_fwd_m1;
    logic [SIZE_W-1:0] w_j_p1;
    logic [POS_W-1:0]  w_i_m1;

    beat_t             r_out;
    logic              r_out_valid;
    beat_t             r_skid;
    logic              r_skid_full;
    logic [CNT_W-1:0]  r_finish_cnt;
    logic              r_err;

    logic              w_accept;
    logic              w_out_free;
    logic              w_out_fire;

    assign w_last_m1 = in_new_last_size - SIZE_W'(1);
    assign w_fwd_m1  = in_fwd_size_n - SIZE_W'(1);
    assign w_j_p1    = in_bck_j + SIZE_W'(1);
    assign w_i_m1    = in_bck_i - POS_W'(1);
    // new_last_size == 0 wraps to all-ones, so j_bound then fires at j == max
    assign w_jbound  = (in_bck_j == w_last_m1);
    assign w_i_step  = w_jbound & (in_bck_i > I_FLOOR_P);
    assign w_i_end   = w_jbound & (in_bck_i == I_FLOOR_P);

    // Stage p0: combinational loop update of the accepted beat
    always_comb begin
        w_in = '{status: in_status, read_num: in_read_num, primary: in_primary,
                 fwd_size_n: in_fwd_size_n, new_size: in_new_size,
                 new_last_size: in_new_last_size, cur_wr_addr: in_cur_wr_addr,
                 cur_rd_addr: in_cur_rd_addr, mem_wr_addr: in_mem_wr_addr,
                 bck_i: in_bck_i, bck_j: in_bck_j, output_c: in_output_c,
                 min_intv: in_min_intv, reserved: in_reserved,
                 finish: 1'b0, boundary: in_iter_bound};
        w_res     = bubble_beat();
        w_unknown = 1'b0;
        case (in_status)
            ST_INI: begin
                w_res          = w_in;
                w_res.output_c = '0;
            end
            ST_RUN: begin
                w_res               = w_in;
                w_res.finish        = w_jbound & (in_new_size == '0);
                w_res.boundary      = in_iter_bound | w_i_end;
                w_res.bck_i         = in_iter_bound ? I_FLOOR_P : (w_i_step ? w_i_m1 : in_bck_i);
                w_res.bck_j         = w_jbound ? '0 : w_j_p1;
                w_res.cur_wr_addr   = w_jbound ? w_fwd_m1 : in_cur_wr_addr;
                w_res.new_last_size = w_jbound ? in_new_size : in_new_last_size;
                w_res.new_size      = w_jbound ? '0 : in_new_size;
            end
            ST_BUBBLE: ;
            default: w_unknown = 1'b1;
        endcase
    end

    assign w_accept   = in_valid & ~r_skid_full;
    assign w_out_free = ~r_out_valid | out_ready;
    assign w_out_fire = r_out_valid & out_ready;

    // Stage p1: output register with skid buffer behind it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out       <= bubble_beat();
            r_out_valid <= 1'b0;
            r_skid_full <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_full) begin
                r_out       <= r_skid;
                r_out_valid <= 1'b1;
                r_skid_full <= 1'b0;
            end else if (w_accept) begin
                r_out       <= w_res;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!w_out_free && w_accept) begin
            r_skid <= w_res;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_finish_cnt <= '0;
            r_err        <= 1'b0;
        end else begin
            if (cnt_clr) begin
                r_finish_cnt <= '0;
            end else if (w_out_fire && r_out.finish) begin
                r_finish_cnt <= sat_inc(r_finish_cnt);
            end
            if (w_accept && w_unknown) begin
                r_err <= 1'b1;
            end
        end
    end

    assign in_ready           = ~r_skid_full;
    assign out_valid          = r_out_valid;
    assign out_status         = r_out.status;
    assign out_read_num       = r_out.read_num;
    assign out_primary        = r_out.primary;
    assign out_fwd_size_n     = r_out.fwd_size_n;
    assign out_new_size       = r_out.new_size;
    assign out_new_last_size  = r_out.new_last_size;
    assign out_cur_wr_addr    = r_out.cur_wr_addr;
    assign out_cur_rd_addr    = r_out.cur_rd_addr;
    assign out_mem_wr_addr    = r_out.mem_wr_addr;
    assign out_bck_i          = r_out.bck_i;
    assign out_bck_j          = r_out.bck_j;
    assign out_output_c       = r_out.output_c;
    assign out_min_intv       = r_out.min_intv;
    assign out_reserved       = r_out.reserved;
    assign finish_sign        = r_out.finish;
    assign iteration_boundary = r_out.boundary;
    assign finish_cnt         = r_finish_cnt;
    assign err_status         = r_err;

endmodule

// File: tb/tb_bck_loop_ctrl_stage.sv
// Scoreboard bench for bck_loop_ctrl_stage: accepted beats are modelled into a queue,
// a monitor pops and compares on every output transfer.
module tb_bck_loop_ctrl_stage;

    localparam int RW = 10, SW = 7, PW = 7, PRW = 64, RSW = 96, CW = 4, FLOOR = 3;
    localparam logic [5:0] S_INI = 6'h1, S_RUN = 6'h2, S_BUB = 6'h1e;

    typedef struct packed {
        logic [5:0]     status;
        logic [RW-1:0]  rn;
        logic [PRW-1:0] prim;
        logic [SW-1:0]  fsn;
        logic [SW-1:0]  ns;
        logic [SW-1:0]  nls;
        logic [SW-1:0]  cwa;
        logic [SW-1:0]  cra;
        logic [SW-1:0]  mwa;
        logic [PW-1:0]  i;
        logic [SW-1:0]  j;
        logic [7:0]     oc;
        logic [SW-1:0]  mi;
        logic [RSW-1:0] rsv;
        logic           fin;
        logic           bnd;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, out_valid, out_ready;
    logic [5:0] in_status, out_status;
    logic [RW-1:0] in_read_num, out_read_num;
    logic [PRW-1:0] in_primary, out_primary;
    logic [SW-1:0] in_fwd_size_n, in_new_size, in_new_last_size, in_cur_wr_addr, in_cur_rd_addr;
    logic [SW-1:0] in_mem_wr_addr, in_bck_j, in_min_intv;
    logic [SW-1:0] out_fwd_size_n, out_new_size, out_new_last_size, out_cur_wr_addr, out_cur_rd_addr;
    logic [SW-1:0] out_mem_wr_addr, out_bck_j, out_min_intv;
    logic [PW-1:0] in_bck_i, out_bck_i;
    logic [7:0] in_output_c, out_output_c;
    logic in_iter_bound;
    logic [RSW-1:0] in_reserved, out_reserved;
    logic finish_sign, iteration_boundary, cnt_clr, err_status;
    logic [CW-1:0] finish_cnt;

    int    n_pass = 0, n_total = 0;
    beat_t q[$];
    int    model_cnt = 0;
    bit    err_model = 0;
    bit    rand_rdy = 0;
    int    stall_seen = 0;

    bck_loop_ctrl_stage #(.READ_NUM_W(RW), .SIZE_W(SW), .POS_W(PW), .PRIM_W(PRW), .RSV_W(RSW),
                          .CNT_W(CW), .I_FLOOR(FLOOR), .ST_INI(S_INI), .ST_RUN(S_RUN),
                          .ST_BUBBLE(S_BUB)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_status(in_status), .in_read_num(in_read_num), .in_primary(in_primary),
        .in_fwd_size_n(in_fwd_size_n), .in_new_size(in_new_size),
        .in_new_last_size(in_new_last_size), .in_cur_wr_addr(in_cur_wr_addr),
        .in_cur_rd_addr(in_cur_rd_addr), .in_mem_wr_addr(in_mem_wr_addr),
        .in_bck_i(in_bck_i), .in_bck_j(in_bck_j), .in_output_c(in_output_c),
        .in_min_intv(in_min_intv), .in_iter_bound(in_iter_bound), .in_reserved(in_reserved),
        .out_valid(out_valid), .out_ready(out_ready), .out_status(out_status),
        .out_read_num(out_read_num), .out_primary(out_primary), .out_fwd_size_n(out_fwd_size_n),
        .out_new_size(out_new_size), .out_new_last_size(out_new_last_size),
        .out_cur_wr_addr(out_cur_wr_addr), .out_cur_rd_addr(out_cur_rd_addr),
        .out_mem_wr_addr(out_mem_wr_addr), .out_bck_i(out_bck_i), .out_bck_j(out_bck_j),
        .out_output_c(out_output_c), .out_min_intv(out_min_intv), .out_reserved(out_reserved),
        .finish_sign(finish_sign), .iteration_boundary(iteration_boundary),
        .finish_cnt(finish_cnt), .cnt_clr(cnt_clr), .err_status(err_status)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic beat_t cur_in();
        return '{status: in_status, rn: in_read_num, prim: in_primary, fsn: in_fwd_size_n,
                 ns: in_new_size, nls: in_new_last_size, cwa: in_cur_wr_addr, cra: in_cur_rd_addr,
                 mwa: in_mem_wr_addr, i: in_bck_i, j: in_bck_j, oc: in_output_c,
                 mi: in_min_intv, rsv: in_reserved, fin: 1'b0, bnd: in_iter_bound};
    endfunction

    function automatic beat_t dut_out();
        return '{status: out_status, rn: out_read_num, prim: out_primary, fsn: out_fwd_size_n,
                 ns: out_new_size, nls: out_new_last_size, cwa: out_cur_wr_addr,
                 cra: out_cur_rd_addr, mwa: out_mem_wr_addr, i: out_bck_i, j: out_bck_j,
                 oc: out_output_c, mi: out_min_intv, rsv: out_reserved, fin: finish_sign,
                 bnd: iteration_boundary};
    endfunction

    // Reference: loop rules evaluated with integer arithmetic modulo 2^SW
    function automatic beat_t model(input beat_t b);
        beat_t e;
        int m, j, nls, i;
        bit jb;
        e        = '0;
        e.status = S_BUB;
        m   = 1 << SW;
        j   = int'(b.j);
        nls = int'(b.nls);
        i   = int'(b.i);
        if (b.status == S_INI) begin
            e     = b;
            e.oc  = '0;
            e.fin = 1'b0;
        end else if (b.status == S_RUN) begin
            jb    = (j == (nls + m - 1) % m);
            e     = b;
            e.fin = jb && (b.ns == '0);
            e.bnd = b.bnd || (jb && i == FLOOR);
            if (b.bnd) e.i = PW'(FLOOR);
            else if (jb && i > FLOOR) e.i = PW'(i - 1);
            e.j = jb ? '0 : SW'((j + 1) % m);
            if (jb) begin
                e.cwa = SW'((int'(b.fsn) + m - 1) % m);
                e.nls = b.ns;
                e.ns  = '0;
            end
        end
        return e;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        int    s;
        s = $urandom_range(0, 9);
        b.status = (s < 4) ? S_RUN : (s < 6) ? S_INI : (s < 8) ? S_BUB : 6'($urandom);
        b.rn   = RW'($urandom);
        b.prim = {$urandom, $urandom};
        b.fsn  = SW'($urandom);
        b.ns   = ($urandom_range(0, 2) == 0) ? '0 : SW'($urandom);
        b.nls  = ($urandom_range(0, 4) == 0) ? '0 : SW'($urandom);
        b.cwa  = SW'($urandom);
        b.cra  = SW'($urandom);
        b.mwa  = SW'($urandom);
        b.i    = ($urandom_range(0, 1) == 0) ? PW'($urandom_range(0, 6)) : PW'($urandom);
        b.j    = ($urandom_range(0, 1) == 0) ? SW'(b.nls - 1'b1) : SW'($urandom);
        b.oc   = 8'($urandom);
        b.mi   = SW'($urandom);
        b.rsv  = {$urandom, $urandom, $urandom};
        b.fin  = 1'b0;
        b.bnd  = ($urandom_range(0, 4) == 0);
        return b;
    endfunction

    function automatic beat_t mk_run(input int j, input int nls, input int i, input int ns,
                                     input int fsn);
        beat_t b;
        b        = rand_beat();
        b.status = S_RUN;
        b.j      = SW'(j);
        b.nls    = SW'(nls);
        b.i      = PW'(i);
        b.ns     = SW'(ns);
        b.fsn    = SW'(fsn);
        b.bnd    = 1'b0;
        return b;
    endfunction

    task automatic drive(input beat_t b);
        in_status = b.status; in_read_num = b.rn; in_primary = b.prim; in_fwd_size_n = b.fsn;
        in_new_size = b.ns; in_new_last_size = b.nls; in_cur_wr_addr = b.cwa;
        in_cur_rd_addr = b.cra; in_mem_wr_addr = b.mwa; in_bck_i = b.i; in_bck_j = b.j;
        in_output_c = b.oc; in_min_intv = b.mi; in_reserved = b.rsv; in_iter_bound = b.bnd;
    endtask

    task automatic knobs();
        if (rand_rdy) begin
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 19) == 0);
        end
    endtask

    task automatic send(input beat_t b);
        int waits;
        waits = 0;
        @(negedge clk);
        drive(b);
        in_valid = 1'b1;
        knobs();
        #2;
        while (!in_ready) begin
            stall_seen++;
            waits++;
            if (waits > 200) begin
                n_total++;
                $display("FAIL send_timeout: in_ready low for %0d cycles, required high", waits);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            knobs();
            #2;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        knobs();
    endtask

    task automatic one(input beat_t b);
        send(b);
        idle();
        #2;
    endtask

    task automatic check_reset(input string tag);
        beat_t z;
        z        = '0;
        z.status = S_BUB;
        check({tag, "_out_valid"}, 256'(out_valid), 256'(0));
        check({tag, "_in_ready"}, 256'(in_ready), 256'(1));
        check({tag, "_beat"}, 256'(dut_out()), 256'(z));
        check({tag, "_finish_cnt"}, 256'(finish_cnt), 256'(0));
        check({tag, "_err_status"}, 256'(err_status), 256'(0));
    endtask

    // Expectation producer: models every accepted beat
    always begin
        beat_t b;
        @(negedge clk);
        #2;
        if (rst !== 1'b1) begin
            err_model = 0;
        end else begin
            check("err_status", 256'(err_status), 256'(err_model));
            if (in_valid && in_ready) begin
                b = cur_in();
                q.push_back(model(b));
                if (b.status != S_INI && b.status != S_RUN && b.status != S_BUB) err_model = 1;
            end
        end
    end

    // Monitor: compares each output transfer against the oldest expectation
    always begin
        beat_t e;
        bit    fire;
        @(negedge clk);
        #2;
        if (rst !== 1'b1) begin
            q.delete();
            model_cnt = 0;
        end else begin
            check("finish_cnt", 256'(finish_cnt), 256'(model_cnt));
            fire = out_valid && out_ready;
            e    = '0;
            if (fire) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL beat_unexpected: got %0h with no beat outstanding", dut_out());
                end else begin
                    e = q.pop_front();
                    check("beat", 256'(dut_out()), 256'(e));
                end
            end
            if (cnt_clr) model_cnt = 0;
            else if (fire && e.fin) model_cnt = (model_cnt == (1 << CW) - 1) ? model_cnt : model_cnt + 1;
        end
    end

    initial begin
        beat_t b;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        b = '0;
        drive(b);
        #12;
        check_reset("reset");
        @(negedge clk);
        rst = 1'b1;

        one(mk_run(2, 3, 5, 4, 10));
        check("t1_latency_valid", 256'(out_valid), 256'(1));
        check("t1_bck_j", 256'(out_bck_j), 256'(0));
        check("t1_bck_i", 256'(out_bck_i), 256'(4));
        check("t1_new_last_size", 256'(out_new_last_size), 256'(4));
        check("t1_new_size", 256'(out_new_size), 256'(0));
        check("t1_cur_wr_addr", 256'(out_cur_wr_addr), 256'(9));
        check("t1_flags", 256'({finish_sign, iteration_boundary}), 256'(0));

        one(mk_run(2, 3, FLOOR, 0, 10));
        check("t2_flags", 256'({finish_sign, iteration_boundary}), 256'(3));
        check("t2_bck_i", 256'(out_bck_i), 256'(FLOOR));
        idle();
        #2;
        check("t2_finish_cnt", 256'(finish_cnt), 256'(1));

        b = mk_run(127, 0, 6, 17, 20);
        one(b);
        check("t3_wrap_bck_j", 256'(out_bck_j), 256'(0));
        check("t3_wrap_new_last", 256'(out_new_last_size), 256'(17));
        b = mk_run(5, 9, 6, 17, 20);
        one(b);
        check("t3_bck_j", 256'(out_bck_j), 256'(6));
        check("t3_keep_fields", 256'({out_bck_i, out_new_size, out_new_last_size, out_cur_wr_addr}),
              256'({b.i, b.ns, b.nls, b.cwa}));

        b = rand_beat();
        b.status = S_INI;
        b.oc     = 8'h41;
        one(b);
        check("ini_output_c", 256'(out_output_c), 256'(0));
        check("ini_finish", 256'(finish_sign), 256'(0));
        b.status = S_BUB;
        one(b);
        check("bubble_primary", 256'({out_status, out_primary}), 256'({S_BUB, 64'd0}));
        check("err_before", 256'(err_status), 256'(0));
        b.status = 6'h3f;
        one(b);
        check("unknown_status_out", 256'(out_status), 256'(S_BUB));
        check("err_after", 256'(err_status), 256'(1));

        // Stream of 4 beats, output stalled for three cycles
        stall_seen = 0;
        fork
            begin
                for (int k = 0; k < 4; k++) send(rand_beat());
                idle();
            end
            begin
                @(negedge clk);
                @(negedge clk);
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        repeat (4) idle();
        #2;
        check("stream_in_ready_dropped", 256'(stall_seen != 0), 256'(1));
        check("stream_drained", 256'(q.size()), 256'(0));

        // Reset while output and skid both hold beats
        out_ready = 1'b0;
        send(rand_beat());
        send(rand_beat());
        idle();
        #2;
        check("skid_full_in_ready", 256'(in_ready), 256'(0));
        #1;
        rst = 1'b0;
        #1;
        check_reset("midreset");
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        rst = 1'b1;

        // Saturate the finish counter, then clear it alongside a finish beat
        for (int k = 0; k < (1 << CW) + 1; k++) begin
            b = mk_run(0, 1, $urandom_range(0, 100), 0, $urandom_range(0, 127));
            send(b);
        end
        repeat (3) idle();
        #2;
        check("finish_cnt_saturated", 256'(finish_cnt), 256'((1 << CW) - 1));
        send(mk_run(0, 1, 9, 0, 4));
        @(negedge clk);
        in_valid = 1'b0;
        cnt_clr  = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        #2;
        check("cnt_clr_priority", 256'(finish_cnt), 256'(0));

        rand_rdy = 1;
        for (int k = 0; k < 300; k++) begin
            send(rand_beat());
            if ($urandom_range(0, 3) == 0) idle();
        end
        rand_rdy  = 0;
        idle();
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        repeat (5) idle();
        #2;
        check("random_drained", 256'(q.size()), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
